pool_relu_stage_1: RTL and testbench
====================================

// Module: pool_relu_stage_1
// PURPOSE
// - Downstream of the conv control/MAC stage: takes one accumulated conv pixel per pulse,
//   rescales and saturates it to DATA_WIDTH, then runs 2x2 stride-2 max pooling.
// - Writes pooled pixels in order to the output-feature M9K, starting at address 0.
// - Raises pool_done after the last pooled pixel of the last map.
// PARAMETERS
// - DATA_WIDTH        16  signed width of pooled output word
// - ACC_WIDTH         36  signed width of incoming accumulator pixel
// - FRAC_SHIFT        8   arithmetic right shift applied before saturation
// - OUT_FEATURE_WIDTH 24  conv output map width=height; must be even
// - NUM_ONEMULT       2   maps per run, streamed back to back
// - POOL_ADDR_WIDTH   10  output address width; >= clog2(NUM_ONEMULT*(W/2)^2)
// PORTS
// - clock        in   1                clock, rising edge
// - reset        in   1                asynchronous, active-high
// - enable       in   1                global enable; 0 freezes all state except reset
// - start        in   1                level from conv control; first 0->1 arms the stage
// - conv_done    in   1                conv control finished all pixels
// - pixel_valid  in   1                one-cycle pulse: pixel_data holds a finished sum
// - pixel_data   in   ACC_WIDTH        signed accumulated conv pixel
// - pool_wren    out  1                write strobe to output M9K, one cycle
// - pool_addr    out  POOL_ADDR_WIDTH  write address
// - pool_data    out  DATA_WIDTH       signed pooled value
// - pool_done    out  1                sticky: all pooled pixels written
// - pool_err     out  1                sticky: conv_done came before all pixels
// BEHAVIOUR
// - Reset (async) clears to 0: pool_wren, pool_addr, pool_data, pool_done, pool_err,
//   the FSM (IDLE), all counters and the line buffer. Reset mid-run aborts with no write.
// - All sequential state advances only when enable=1.
// - FSM states: IDLE, RUN, DONE, ERR.
//   IDLE->RUN on start=1 (start is sampled, and its 0->1 edge registered).
//   RUN->DONE after the cycle that writes pooled pixel NUM_ONEMULT*(W/2)^2-1.
//   RUN->ERR if conv_done=1 and the pixel count is below NUM_ONEMULT*W*W.
//   DONE and ERR are terminal until reset.
// - pixel_valid is ignored outside RUN. In RUN, a pixel is accepted on each pulse.
// - If pixel_valid and conv_done are both high in one cycle, the pixel is accepted first.
//   The ERR check then uses the updated count.
// - Scaling: s = pixel_data >>> FRAC_SHIFT (sign-preserving).
//   s saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
// - Counters: col 0..W-1, row 0..W-1, map 0..NUM_ONEMULT-1.
//   col wraps and increments row; row wraps and increments map.
// - Even col: hold s in reg h. Odd col: hm = max(h, s), signed compare.
// - Even row, odd col: linebuf[col/2] <= hm.
// - Odd row, odd col: one cycle later pool_wren=1,
//   pool_data=max(linebuf[col/2], hm), pool_addr=current write pointer.
//   The write pointer then increments by 1.
// - Latency: pool_wren rises 1 cycle after the pixel_valid of the bottom-right pixel
//   of each 2x2 window. pool_wren stays high for 1 cycle only.
// - Line buffer holds W/2 words; the next even row overwrites it.
//   No clear is needed between maps.
// - pool_addr holds its last value when idle. The pointer never exceeds
//   NUM_ONEMULT*(W/2)^2-1.
// - Ties in max pick either value (they are equal).
//   Strict signed compare: -1 > -2^(DATA_WIDTH-1).
// - pool_done goes to 1 in the cycle after the final write, i.e. when entering DONE.
// CONFIGURATION
// - RELU_EN defined: after saturation, a negative s is forced to 0 before pooling.
//   pool_data is then always >= 0.
// - RELU_EN undefined: no clamp; signed pooling passes negative values through.
// TESTING
// - Setup: OUT_FEATURE_WIDTH=4, NUM_ONEMULT=2, FRAC_SHIFT=0.
// - Ramp: feed data = pixel index 0..15 per map -> 4 writes per map with data 5,7,13,15.
//   Addresses 0..7 over both maps; pool_done=1 one cycle after the addr-7 write.
// - Saturation: data = 2^20 and -2^20 with FRAC_SHIFT=0 -> pooled 32767,
//   and -32768 where a window is all -2^20.
// - Negatives: a window {-5,-3,-9,-7}, RELU_EN off -> pool_data = -3 (0xFFFD).
//   RELU_EN on -> pool_data = 0.
// - Early conv_done: pulse conv_done after 10 pixels -> pool_err=1 next cycle.
//   No further pool_wren; pool_done stays 0.
// - Async reset mid-run: assert reset between clock edges after 6 pixels -> all outputs 0
//   immediately. A rerun from start gives exactly the ramp result at addr 0.
// - Gating: pixel_valid pulses before start, and pixel_valid with enable=0 ->
//   no counter change, no pool_wren.

Source files
------------

// File: rtl/pool_relu_stage_1.sv
// Rescale/saturate conv pixels, 2x2 stride-2 max pool, write to output M9K; write 1 cycle after window's last pixel.
// No backpressure: enable stalls everything; optional ReLU clamp under `define RELU_EN.
module pool_relu_stage_1 #(
    parameter int DATA_WIDTH        = 16,
    parameter int ACC_WIDTH         = 36,
    parameter int FRAC_SHIFT        = 8,
    parameter int OUT_FEATURE_WIDTH = 24,
    parameter int NUM_ONEMULT       = 2,
    parameter int POOL_ADDR_WIDTH   = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        start,
    input  logic                        conv_done,
    input  logic                        pixel_valid,
    input  logic signed [ACC_WIDTH-1:0] pixel_data,
    output logic                        pool_wren,
    output logic [POOL_ADDR_WIDTH-1:0]  pool_addr,
    output logic signed [DATA_WIDTH-1:0] pool_data,
    output logic                        pool_done,
    output logic                        pool_err
);
    localparam int W         = OUT_FEATURE_WIDTH;
    localparam int CW        = $clog2(W);
    localparam int HW        = $clog2(W / 2);
    localparam int MW        = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;
    localparam int TOTAL_PIX = NUM_ONEMULT * W * W;
    localparam int PCW       = $clog2(TOTAL_PIX + 1);
    localparam int LAST_WR   = NUM_ONEMULT * (W / 2) * (W / 2) - 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
    state_t state_q, state_d;

    logic                         start_q;
    logic [CW-1:0]                col, row;
    logic [MW-1:0]                map;
    logic [PCW-1:0]               pix_cnt, pix_cnt_nxt;
    logic [POOL_ADDR_WIDTH-1:0]   wr_ptr;
    logic                         fin;
    logic signed [DATA_WIDTH-1:0] h_q;
    logic signed [DATA_WIDTH-1:0] linebuf [W/2];

    logic                         accept;
    logic [HW-1:0]                half;
    logic signed [ACC_WIDTH-1:0]  s_shift;
    logic signed [DATA_WIDTH-1:0] s_sat, s_pool, hm, lb_rd, win;

    // Pixels beyond the full run count are dropped so the counters cannot run past the end
    assign accept      = enable && (state_q == RUN) && pixel_valid && (pix_cnt != PCW'(TOTAL_PIX));
    assign pix_cnt_nxt = pix_cnt + PCW'(accept);
    assign half        = col[CW-1:1];
    assign s_shift     = pixel_data >>> FRAC_SHIFT;

    always_comb begin
        s_sat = s_shift[DATA_WIDTH-1:0];
        if (s_shift > SAT_MAX)
            s_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (s_shift < SAT_MIN)
            s_sat = SAT_MIN[DATA_WIDTH-1:0];
    end

`ifdef RELU_EN
    assign s_pool = s_sat[DATA_WIDTH-1] ? '0 : s_sat;
`else
    assign s_pool = s_sat;
`endif

    assign hm    = (h_q > s_pool) ? h_q : s_pool;
    assign lb_rd = linebuf[half];
    assign win   = (lb_rd > hm) ? lb_rd : hm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else if (enable)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !start_q) state_d = RUN;
            RUN: begin
                if (fin)
                    state_d = DONE;
                else if (conv_done && (pix_cnt_nxt < PCW'(TOTAL_PIX)))
                    state_d = ERR;
            end
            default: state_d = state_q;
        endcase
    end

    // pool_wren is a one-cycle strobe and drops even while enable is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q   <= 1'b0;
            col       <= '0;
            row       <= '0;
            map       <= '0;
            pix_cnt   <= '0;
            wr_ptr    <= '0;
            fin       <= 1'b0;
            h_q       <= '0;
            pool_wren <= 1'b0;
            pool_addr <= '0;
            pool_data <= '0;
            for (int i = 0; i < W / 2; i++)
                linebuf[i] <= '0;
        end else begin
            pool_wren <= 1'b0;
            if (enable)
                start_q <= start;
            if (accept) begin
                pix_cnt <= pix_cnt_nxt;
                if (col == CW'(W - 1)) begin
                    col <= '0;
                    if (row == CW'(W - 1)) begin
                        row <= '0;
                        map <= (map == MW'(NUM_ONEMULT - 1)) ? '0 : map + MW'(1);
                    end else begin
                        row <= row + CW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end

                if (!col[0]) begin
                    h_q <= s_pool;
                end else if (!row[0]) begin
                    linebuf[half] <= hm;
                end else begin
                    pool_wren <= 1'b1;
                    pool_data <= win;
                    pool_addr <= wr_ptr;
                    if (wr_ptr == POOL_ADDR_WIDTH'(LAST_WR))
                        fin <= 1'b1;
                    else
                        wr_ptr <= wr_ptr + POOL_ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign pool_done = (state_q == DONE);
    assign pool_err  = (state_q == ERR);

endmodule

// File: tb/tb_pool_relu_stage_1.sv
// Bench for pool_relu_stage_1 at W=4, two maps, no fractional shift; honours RELU_EN if defined.
module tb_pool_relu_stage_1;
    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               start;
    logic               conv_done;
    logic               pixel_valid;
    logic signed [35:0] pixel_data;
    logic               pool_wren;
    logic [9:0]         pool_addr;
    logic signed [15:0] pool_data;
    logic               pool_done;
    logic               pool_err;

    pool_relu_stage_1 #(
        .DATA_WIDTH(16), .ACC_WIDTH(36), .FRAC_SHIFT(0),
        .OUT_FEATURE_WIDTH(4), .NUM_ONEMULT(2), .POOL_ADDR_WIDTH(10)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .conv_done(conv_done), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pool_wren(pool_wren), .pool_addr(pool_addr), .pool_data(pool_data),
        .pool_done(pool_done), .pool_err(pool_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]         addr;
        logic signed [15:0] data;
    } exp_t;

    typedef struct {
        logic signed [35:0] w [4];
        logic signed [15:0] exp;
    } win_t;

    exp_t               exp_q [$];
    exp_t               mon_e;
    win_t               tbl [8];
    logic signed [35:0] img [16];
    logic signed [15:0] wexp [4];
    int                 exp_addr;
    int                 n_chk = 0;
    int                 n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic signed [15:0] relu16(input logic signed [15:0] x);
`ifdef RELU_EN
        return (x < 0) ? 16'sd0 : x;
`else
        return x;
`endif
    endfunction

    always @(negedge clock) begin
        if (!reset && pool_wren) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d data=%0d, expected no write", pool_addr, pool_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(pool_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(pool_data), 32'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        start = 0; enable = 1; conv_done = 0; pixel_valid = 0; pixel_data = '0;
        reset = 1;
        tick(); tick();
        reset = 0;
        exp_addr = 0;
        tick();
    endtask

    task automatic arm();
        start = 1;
        tick();
    endtask

    // Drives the first n raster pixels of img; expectation queued on each window's last pixel
    task automatic feed_map(input int n);
        for (int i = 0; i < n; i++) begin
            int r, c;
            r = i / 4;
            c = i % 4;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_q.push_back('{addr: 10'(exp_addr), data: wexp[(r / 2) * 2 + c / 2]});
                exp_addr++;
            end
            pixel_valid = 1;
            pixel_data  = img[i];
            tick();
        end
        pixel_valid = 0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) img[i] = 36'(i);
        wexp[0] = 16'sd5; wexp[1] = 16'sd7; wexp[2] = 16'sd13; wexp[3] = 16'sd15;
    endtask

    task automatic load_table_map(input int m);
        for (int k = 0; k < 4; k++) begin
            int base;
            base = (k / 2) * 8 + (k % 2) * 2;
            img[base]     = tbl[4*m+k].w[0];
            img[base + 1] = tbl[4*m+k].w[1];
            img[base + 4] = tbl[4*m+k].w[2];
            img[base + 5] = tbl[4*m+k].w[3];
            wexp[k] = relu16(tbl[4*m+k].exp);
        end
    endtask

    initial begin
        tbl[0] = '{w: '{36'sd1, 36'sd2, 36'sd3, 36'sd4}, exp: 16'sd4};
        tbl[1] = '{w: '{36'sd1048576, 36'sd0, 36'sd0, 36'sd0}, exp: 16'sd32767};
        tbl[2] = '{w: '{-36'sd1048576, -36'sd1048576, -36'sd1048576, -36'sd1048576}, exp: -16'sd32768};
        tbl[3] = '{w: '{-36'sd5, -36'sd3, -36'sd9, -36'sd7}, exp: -16'sd3};
        tbl[4] = '{w: '{36'sd100, -36'sd100, 36'sd50, 36'sd99}, exp: 16'sd100};
        tbl[5] = '{w: '{-36'sd1, -36'sd1048576, -36'sd1048576, -36'sd1048576}, exp: -16'sd1};
        tbl[6] = '{w: '{36'sd32767, 36'sd32768, 36'sd5, 36'sd6}, exp: 16'sd32767};
        tbl[7] = '{w: '{-36'sd7, -36'sd7, -36'sd7, -36'sd7}, exp: -16'sd7};

        // Ramp run with gating: pulses before start and with enable low must be ignored
        do_reset();
        chk("rst_wren", 32'(pool_wren), 0);
        chk("rst_addr", 32'(pool_addr), 0);
        chk("rst_data", 32'(pool_data), 0);
        chk("rst_done", 32'(pool_done), 0);
        chk("rst_err",  32'(pool_err), 0);
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1; pixel_data = 36'sd999;
            tick();
        end
        pixel_valid = 0;
        arm();
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1; pixel_data = 36'sd888;
            tick();
        end
        pixel_valid = 0;
        enable = 1;
        load_ramp();
        feed_map(16);
        feed_map(16);
        chk("done_at_last_write", 32'(pool_done), 0);
        tick();
        chk("done_after_last", 32'(pool_done), 1);
        conv_done = 1; tick(); conv_done = 0;
        chk("no_err_after_done", 32'(pool_err), 0);
        chk("ramp_all_written", 32'(exp_q.size()), 0);
        exp_q.delete();

        // Table-driven windows: saturation, negatives, ties
        do_reset();
        arm();
        for (int m = 0; m < 2; m++) begin
            load_table_map(m);
            feed_map(16);
        end
        tick();
        chk("tbl_done", 32'(pool_done), 1);
        chk("tbl_all_written", 32'(exp_q.size()), 0);
        exp_q.delete();

        // Early conv_done after 10 pixels
        do_reset();
        arm();
        load_ramp();
        feed_map(10);
        conv_done = 1; tick(); conv_done = 0;
        chk("early_err", 32'(pool_err), 1);
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1; pixel_data = 36'(i + 10);
            tick();
        end
        pixel_valid = 0;
        tick();
        chk("early_err_sticky", 32'(pool_err), 1);
        chk("early_no_done", 32'(pool_done), 0);
        chk("early_writes", 32'(exp_q.size()), 0);
        exp_q.delete();

        // Async reset mid-run, then a clean rerun
        do_reset();
        arm();
        load_ramp();
        feed_map(6);
        @(negedge clock); #1;
        reset = 1;
        #1;
        chk("arst_wren", 32'(pool_wren), 0);
        chk("arst_addr", 32'(pool_addr), 0);
        chk("arst_data", 32'(pool_data), 0);
        chk("arst_done", 32'(pool_done), 0);
        chk("arst_err",  32'(pool_err), 0);
        exp_q.delete();
        do_reset();
        arm();
        feed_map(16);
        feed_map(16);
        tick();
        chk("rerun_done", 32'(pool_done), 1);
        chk("rerun_all_written", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
